bp_nonsynth_mem_model: RTL and testbench

// - Non-synthesizable backing-memory model for cache/coherence testbenches.
// - Sits on the CCE/UCE memory side and accepts BedRock mem_cmd messages (header + block data).
// - Reads or writes a byte-addressed array and returns one mem_resp per command after a fixed latency.
// - Single-clock, one transaction outstanding.

---
 rtl/bp_nonsynth_mem_model_pkg.sv | 45 ++++
 rtl/bp_nonsynth_mem_model_array.sv | 60 ++++++
 rtl/bp_nonsynth_mem_model.sv | 120 ++++++++++++
 tb/tb_bp_nonsynth_mem_model.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/bp_nonsynth_mem_model_pkg.sv
// Shared BedRock memory-message definitions for the backing-memory model.
// Holds the message encodings, FSM states and header width helpers.
package bp_nonsynth_mem_model_pkg;

  localparam int bedrock_msg_type_width_gp = 4;
  localparam int bedrock_msg_size_width_gp = 3;

  typedef enum logic [3:0] {
    e_bedrock_mem_rd    = 4'd0,
    e_bedrock_mem_wr    = 4'd1,
    e_bedrock_mem_uc_rd = 4'd2,
    e_bedrock_mem_uc_wr = 4'd3
  } bp_bedrock_mem_type_e;

  typedef enum logic [2:0] {
    e_bedrock_msg_size_1   = 3'd0,
    e_bedrock_msg_size_2   = 3'd1,
    e_bedrock_msg_size_4   = 3'd2,
    e_bedrock_msg_size_8   = 3'd3,
    e_bedrock_msg_size_16  = 3'd4,
    e_bedrock_msg_size_32  = 3'd5,
    e_bedrock_msg_size_64  = 3'd6,
    e_bedrock_msg_size_128 = 3'd7
  } bp_bedrock_msg_size_e;

  typedef enum logic [1:0] {
    e_mem_ready,
    e_mem_wait,
    e_mem_resp
  } bp_mem_state_e;

  function automatic int bedrock_mem_hdr_width(input int paddr_width, input int payload_width);
    return bedrock_msg_type_width_gp + paddr_width + bedrock_msg_size_width_gp + payload_width;
  endfunction

  // Unknown message types fall through to reads.
  function automatic logic bedrock_is_write(input logic [3:0] msg_type);
    return (msg_type == e_bedrock_mem_wr) || (msg_type == e_bedrock_mem_uc_wr);
  endfunction

  function automatic logic [2:0] bedrock_cap_size(input logic [2:0] size, input logic [2:0] max_size);
    return (size > max_size) ? max_size : size;
  endfunction

endpackage

// File: rtl/bp_nonsynth_mem_model_array.sv
// Byte-addressed backing array with offset/wrap indexing and sized accesses.
// Reads are combinational; writes land on the clock edge when w_v_i is high.
module bp_nonsynth_mem_array
  import bp_nonsynth_mem_model_pkg::*;
#(
  parameter int                       paddr_width_p      = 40,
  parameter int                       block_width_p      = 512,
  parameter logic [paddr_width_p-1:0] mem_offset_p       = '0,
  parameter int                       mem_cap_in_bytes_p = 2**20,
  parameter bit                       mem_load_p         = 1'b0,
  parameter string                    mem_file_p         = "prog.mem"
)(
  input  logic                     clk_i,
  input  logic                     w_v_i,
  input  logic [paddr_width_p-1:0] addr_i,
  input  logic [2:0]               size_i,
  input  logic [block_width_p-1:0] data_i,
  output logic [block_width_p-1:0] data_o
);

  localparam int         block_bytes_lp = block_width_p / 8;
  localparam int         idx_width_lp   = $clog2(mem_cap_in_bytes_p);
  localparam logic [2:0] block_size_lp  = 3'($clog2(block_bytes_lp));
  localparam int         mask_bits_lp   = (idx_width_lp < 7) ? idx_width_lp : 7;

  logic [7:0] r_mem [mem_cap_in_bytes_p];

  logic [2:0]              w_size;
  logic [idx_width_lp-1:0] w_len_mask;
  logic [idx_width_lp-1:0] w_base;

  // Truncation to the index width is the wrap; the length mask aligns down.
  always_comb begin
    w_size     = bedrock_cap_size(size_i, block_size_lp);
    w_len_mask = '0;
    for (int i = 0; i < mask_bits_lp; i++) begin
      w_len_mask[i] = (i < int'(w_size));
    end
    w_base = idx_width_lp'(addr_i - mem_offset_p) & ~w_len_mask;
  end

  // Short accesses repeat across the data field.
  always_comb begin
    data_o = '0;
    for (int b = 0; b < block_bytes_lp; b++) begin
      data_o[8*b +: 8] = r_mem[w_base + (idx_width_lp'(b) & w_len_mask)];
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_v_i) begin
      for (int b = 0; b < block_bytes_lp; b++) begin
        if ((idx_width_lp'(b) & ~w_len_mask) == '0) begin
          r_mem[w_base + idx_width_lp'(b)] <= data_i[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/bp_nonsynth_mem_model.sv
// BedRock mem_cmd/mem_resp front end over a byte array: one command in flight,
// response after a fixed latency, header echoed bit-exact.
//   state       | meaning
//   e_mem_ready | accepting a command; access happens in the accept cycle
//   e_mem_wait  | counting down the fixed DRAM latency
//   e_mem_resp  | response valid and held until yumi
module bp_nonsynth_mem_model
  import bp_nonsynth_mem_model_pkg::*;
#(
  parameter int                       paddr_width_p        = 40,
  parameter int                       block_width_p        = 512,
  parameter int                       payload_width_p      = 16,
  parameter logic [paddr_width_p-1:0] mem_offset_p         = '0,
  parameter int                       mem_cap_in_bytes_p   = 2**20,
  parameter int                       dram_fixed_latency_p = 0,
  parameter bit                       mem_load_p           = 1'b0,
  parameter string                    mem_file_p           = "prog.mem",
  localparam int hdr_width_lp = bedrock_mem_hdr_width(paddr_width_p, payload_width_p),
  localparam int msg_width_lp = hdr_width_lp + block_width_p
)(
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [msg_width_lp-1:0] mem_cmd_i,
  input  logic                    mem_cmd_v_i,
  output logic                    mem_cmd_ready_and_o,
  output logic [msg_width_lp-1:0] mem_resp_o,
  output logic                    mem_resp_v_o,
  input  logic                    mem_resp_yumi_i
);

  typedef struct packed {
    logic [payload_width_p-1:0] payload;
    logic [2:0]                 size;
    logic [paddr_width_p-1:0]   addr;
    logic [3:0]                 msg_type;
  } hdr_s;

  localparam int lat_cnt_width_lp = (dram_fixed_latency_p > 1) ? $clog2(dram_fixed_latency_p) : 1;
  localparam int lat_init_lp      = (dram_fixed_latency_p > 0) ? dram_fixed_latency_p - 1 : 0;

  hdr_s                        w_cmd_hdr;
  hdr_s                        r_hdr;
  logic [block_width_p-1:0]    w_cmd_data;
  logic [block_width_p-1:0]    w_rd_data;
  logic [block_width_p-1:0]    r_data;
  logic [lat_cnt_width_lp-1:0] r_lat_cnt;
  bp_mem_state_e               r_state;
  bp_mem_state_e               w_state_n;
  logic                        w_accept;
  logic                        w_is_wr;

  assign w_cmd_hdr  = mem_cmd_i[hdr_width_lp-1:0];
  assign w_cmd_data = mem_cmd_i[msg_width_lp-1:hdr_width_lp];
  assign w_is_wr    = bedrock_is_write(w_cmd_hdr.msg_type);
  // Gated by reset so a command presented during reset never touches the array.
  assign w_accept   = mem_cmd_v_i & mem_cmd_ready_and_o & ~reset_i;

  bp_nonsynth_mem_array #(
    .paddr_width_p     (paddr_width_p),
    .block_width_p     (block_width_p),
    .mem_offset_p      (mem_offset_p),
    .mem_cap_in_bytes_p(mem_cap_in_bytes_p),
    .mem_load_p        (mem_load_p),
    .mem_file_p        (mem_file_p)
  ) u_array (
    .clk_i (clk_i),
    .w_v_i (w_accept & w_is_wr),
    .addr_i(w_cmd_hdr.addr),
    .size_i(w_cmd_hdr.size),
    .data_i(w_cmd_data),
    .data_o(w_rd_data)
  );

  always_comb begin
    w_state_n           = r_state;
    mem_cmd_ready_and_o = 1'b0;
    mem_resp_v_o        = 1'b0;
    case (r_state)
      e_mem_ready: begin
        mem_cmd_ready_and_o = 1'b1;
        if (mem_cmd_v_i) begin
          w_state_n = (dram_fixed_latency_p > 0) ? e_mem_wait : e_mem_resp;
        end
      end
      e_mem_wait: begin
        if (r_lat_cnt == '0) begin
          w_state_n = e_mem_resp;
        end
      end
      e_mem_resp: begin
        mem_resp_v_o = 1'b1;
        if (mem_resp_yumi_i) begin
          w_state_n = e_mem_ready;
        end
      end
      default: w_state_n = e_mem_ready;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state   <= e_mem_ready;
      r_hdr     <= '0;
      r_data    <= '0;
      r_lat_cnt <= '0;
    end else begin
      r_state <= w_state_n;
      if (w_accept) begin
        r_hdr     <= w_cmd_hdr;
        r_data    <= w_is_wr ? '0 : w_rd_data;
        r_lat_cnt <= lat_cnt_width_lp'(lat_init_lp);
      end else if ((r_state == e_mem_wait) && (r_lat_cnt != '0)) begin
        r_lat_cnt <= r_lat_cnt - 1'b1;
      end
    end
  end

  assign mem_resp_o = {r_data, r_hdr};

endmodule

// File: tb/tb_bp_nonsynth_mem_model.sv
// Directed bench for bp_nonsynth_mem_model: commands push expected responses
// into a queue, a monitor pops and compares on every consumed response.
module tb_bp_nonsynth_mem_model;

  localparam int          PADDR = 40;
  localparam int          BLK   = 512;
  localparam int          PL    = 16;
  localparam int          HDR   = 4 + PADDR + 3 + PL;
  localparam int          MSG   = HDR + BLK;
  localparam int          LAT   = 5;
  localparam int          CAP   = 2**16;
  localparam logic [39:0] OFF   = 40'h00_8000_0000;

  logic           clk_i = 1'b0;
  logic           reset_i;
  logic [MSG-1:0] mem_cmd_i;
  logic           mem_cmd_v_i;
  logic           mem_cmd_ready_and_o;
  logic [MSG-1:0] mem_resp_o;
  logic           mem_resp_v_o;
  logic           mem_resp_yumi_i;

  int             cyc = 0;
  int             n_checks = 0;
  int             n_pass = 0;
  logic [MSG-1:0] sb_q[$];

  bp_nonsynth_mem_model #(
    .paddr_width_p       (PADDR),
    .block_width_p       (BLK),
    .payload_width_p     (PL),
    .mem_offset_p        (OFF),
    .mem_cap_in_bytes_p  (CAP),
    .dram_fixed_latency_p(LAT),
    .mem_load_p          (1'b0),
    .mem_file_p          ("prog.mem")
  ) dut (
    .clk_i              (clk_i),
    .reset_i            (reset_i),
    .mem_cmd_i          (mem_cmd_i),
    .mem_cmd_v_i        (mem_cmd_v_i),
    .mem_cmd_ready_and_o(mem_cmd_ready_and_o),
    .mem_resp_o         (mem_resp_o),
    .mem_resp_v_o       (mem_resp_v_o),
    .mem_resp_yumi_i    (mem_resp_yumi_i)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc++;

  task automatic check_msg(input string name, input logic [MSG-1:0] act, input logic [MSG-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic logic [BLK-1:0] rep64(input logic [63:0] x);
    logic [BLK-1:0] r;
    for (int i = 0; i < BLK/64; i++) r[64*i +: 64] = x;
    return r;
  endfunction

  function automatic logic [BLK-1:0] rep32(input logic [31:0] x);
    logic [BLK-1:0] r;
    for (int i = 0; i < BLK/32; i++) r[32*i +: 32] = x;
    return r;
  endfunction

  function automatic logic [BLK-1:0] rep16(input logic [15:0] x);
    logic [BLK-1:0] r;
    for (int i = 0; i < BLK/16; i++) r[16*i +: 16] = x;
    return r;
  endfunction

  function automatic logic [BLK-1:0] ramp();
    logic [BLK-1:0] r;
    for (int b = 0; b < BLK/8; b++) r[8*b +: 8] = 8'(b);
    return r;
  endfunction

  // Monitor: every consumed response is matched against the head of the queue.
  always @(negedge clk_i) begin
    logic [MSG-1:0] e;
    if (!reset_i && mem_resp_v_o && mem_resp_yumi_i) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        $display("FAIL resp_unexpected: got %h expected no response", mem_resp_o);
      end else begin
        e = sb_q.pop_front();
        check_msg("resp", mem_resp_o, e);
      end
    end
  end

  task automatic do_cmd(input logic [3:0] t, input logic [39:0] a, input logic [2:0] s,
                        input logic [15:0] pl, input logic [BLK-1:0] d,
                        input logic [BLK-1:0] exp_d, input int hold);
    logic [HDR-1:0] hdr;
    logic [MSG-1:0] exp_msg;
    int             c0, c1;
    bit             ok;
    hdr     = {pl, s, a, t};
    exp_msg = {exp_d, hdr};
    sb_q.push_back(exp_msg);
    mem_cmd_i   = {d, hdr};
    mem_cmd_v_i = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (mem_cmd_ready_and_o) begin ok = 1'b1; break; end
    end
    c0 = cyc;
    @(posedge clk_i); #1;
    mem_cmd_v_i = 1'b0;
    if (!ok) begin
      n_checks++;
      $display("FAIL accept_timeout: got ready=0 expected ready=1 within 20 cycles");
      void'(sb_q.pop_back());
      return;
    end
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_i);
      if (mem_resp_v_o) begin ok = 1'b1; break; end
    end
    c1 = cyc;
    if (!ok) begin
      n_checks++;
      $display("FAIL resp_timeout: got resp_v=0 expected resp_v=1 within 50 cycles");
      void'(sb_q.pop_back());
      return;
    end
    check_int("latency", c1 - c0, LAT + 1);
    for (int i = 0; i < hold; i++) begin
      check_int("hold_resp_v", int'(mem_resp_v_o), 1);
      check_int("hold_ready", int'(mem_cmd_ready_and_o), 0);
      check_msg("hold_resp", mem_resp_o, exp_msg);
      @(negedge clk_i);
    end
    @(posedge clk_i); #1;
    mem_resp_yumi_i = 1'b1;
    @(posedge clk_i); #1;
    mem_resp_yumi_i = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    logic [HDR-1:0] hdr;
    reset_i         = 1'b1;
    mem_cmd_i       = '0;
    mem_cmd_v_i     = 1'b0;
    mem_resp_yumi_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 reset_i = 1'b0;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      check_int("idle_ready", int'(mem_cmd_ready_and_o), 1);
      check_int("idle_resp_v", int'(mem_resp_v_o), 0);
      check_msg("idle_resp", mem_resp_o, '0);
    end
    @(posedge clk_i); #1;

    // type, addr, size, payload, data, expected data, yumi hold
    do_cmd(4'h1, 40'h00_8000_0000, 3'd6, 16'h0001, '0, '0, 0);
    do_cmd(4'h1, 40'h00_8000_0008, 3'd3, 16'h0011, {448'b0, 64'h1122334455667788}, '0, 0);
    do_cmd(4'h0, 40'h00_8000_0008, 3'd3, 16'h0022, rep64(64'hDEADBEEFCAFEF00D),
           rep64(64'h1122334455667788), 0);
    do_cmd(4'h1, 40'h00_8000_0040, 3'd6, 16'h0033, ramp(), '0, 0);
    do_cmd(4'h0, 40'h00_8000_0044, 3'd6, 16'hA5A5, '0, ramp(), 4);
    do_cmd(4'h0, 40'h00_8000_0070, 3'd7, 16'h0044, '0, ramp(), 0);
    do_cmd(4'h3, 40'h00_8000_0003, 3'd0, 16'h0055, {504'b0, 8'hAB}, '0, 0);
    do_cmd(4'h0, 40'h00_8000_0000, 3'd3, 16'h0066, '0, rep64(64'h00000000_AB000000), 0);
    do_cmd(4'h2, 40'h00_8001_0000, 3'd3, 16'h0077, '0, rep64(64'h00000000_AB000000), 1);
    do_cmd(4'hF, 40'h00_8000_000A, 3'd2, 16'h0088, '0, rep32(32'h55667788), 0);
    do_cmd(4'h3, 40'h00_8000_0100, 3'd1, 16'h0099, {496'b0, 16'hBEEF}, '0, 0);
    do_cmd(4'h2, 40'h00_8000_0101, 3'd1, 16'h00AA, '0, rep16(16'hBEEF), 0);

    // Reset while the command sits in WAIT: its response must never appear.
    hdr         = {16'h00BB, 3'd3, 40'h00_8000_0008, 4'h0};
    mem_cmd_i   = {512'b0, hdr};
    mem_cmd_v_i = 1'b1;
    @(negedge clk_i);
    check_int("rst_pre_ready", int'(mem_cmd_ready_and_o), 1);
    @(posedge clk_i); #1;
    mem_cmd_v_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 reset_i = 1'b1;
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    @(negedge clk_i);
    check_int("rst_ready", int'(mem_cmd_ready_and_o), 1);
    check_msg("rst_resp", mem_resp_o, '0);
    for (int i = 0; i < 10; i++) begin
      check_int("rst_resp_v", int'(mem_resp_v_o), 0);
      @(negedge clk_i);
    end
    @(posedge clk_i); #1;

    do_cmd(4'h0, 40'h00_8000_0008, 3'd3, 16'h00CC, '0, rep64(64'h1122334455667788), 0);

    repeat (5) @(posedge clk_i);
    check_int("sb_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
